// File: rtl/inst_mem_wait.sv
// Synchronous-read instruction memory with a valid/ready fetch handshake,
// configurable wait states, a loader write port and address-fault reporting.
module inst_mem_wait #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FAULT_INST  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_inst,
    output logic                  rsp_err,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 32'd0) ? 4'd0 : 4'(WAIT_STATES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_s;
    logic [31:0]             addr_r;
    logic [31:0]             addr_s;
    logic                    capture_s;
    logic [31:0]             cap_addr_s;
    logic                    cap_fault_s;
    logic [DEPTH_LOG2-1:0]   cap_idx_s;
    logic [31:0]             cap_data_s;
    logic                    rsp_valid_r;
    logic [31:0]             rsp_inst_r;
    logic                    rsp_err_r;
    logic                    req_ready_r;
    logic                    busy_r;
    logic [31:0]             mem_r [DEPTH];

    // Misaligned or beyond the implemented word range.
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 32'd2)) != 32'd0);
    endfunction

    // Loader port: contents survive reset, writes are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (ld_we && !rst) begin
            mem_r[ld_addr] <= ld_data;
        end else begin
            mem_r[ld_addr] <= mem_r[ld_addr];
        end
    end

    // Capture path: in IDLE the live request address is used so zero wait
    // states can capture on the accept edge; later captures use the latch.
    always_comb begin
        cap_addr_s = addr_r;
        cap_data_s = FAULT_INST;
        if (state_r == ST_IDLE) begin
            cap_addr_s = req_addr;
        end else begin
            cap_addr_s = addr_r;
        end
        cap_fault_s = addr_fault(cap_addr_s);
        cap_idx_s   = cap_addr_s[DEPTH_LOG2+1:2];
        if (cap_fault_s) begin
            cap_data_s = FAULT_INST;
        end else begin
            cap_data_s = mem_r[cap_idx_s];
        end
    end

    // Next-state logic for the fetch transaction.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = addr_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_s = req_addr;
                    if (WAIT_STATES == 32'd0) begin
                        state_s   = ST_RESP;
                        capture_s = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s   = ST_RESP;
                    capture_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and registered outputs; the response word is frozen after capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_inst_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            addr_r      <= addr_s;
            rsp_valid_r <= (state_s == ST_RESP);
            req_ready_r <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            if (capture_s) begin
                rsp_inst_r <= cap_data_s;
                rsp_err_r  <= cap_fault_s;
            end else begin
                rsp_inst_r <= rsp_inst_r;
                rsp_err_r  <= rsp_err_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_inst  = rsp_inst_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_inst_mem_wait.sv
// Bench for inst_mem_wait: three instances (0, 3 and 2 wait states) checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_inst_mem_wait;

    localparam int N  = 3;
    localparam int DL = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_we, busy;
    logic [31:0]       req_addr [N];
    logic [31:0]       rsp_inst [N];
    logic [DL-1:0]     ld_addr  [N];
    logic [31:0]       ld_data  [N];

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    // transaction-level model state
    bit          m_pend [N];
    bit          m_rsp  [N];
    int          m_left [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_inst [N];
    bit          m_err  [N];
    logic [31:0] m_mem  [N][256];

    always #5 clk = ~clk;

    inst_mem_wait #(.DEPTH_LOG2(DL), .WAIT_STATES(0), .FAULT_INST(32'h0000_0000)) u_ws0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]), .ld_we(ld_we[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .busy(busy[0]));

    inst_mem_wait #(.DEPTH_LOG2(DL), .WAIT_STATES(3), .FAULT_INST(32'h0000_0000)) u_ws3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]), .ld_we(ld_we[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .busy(busy[1]));

    inst_mem_wait #(.DEPTH_LOG2(DL), .WAIT_STATES(2), .FAULT_INST(32'h0BAD_F00D)) u_ws2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_inst(rsp_inst[2]), .rsp_err(rsp_err[2]), .ld_we(ld_we[2]),
        .ld_addr(ld_addr[2]), .ld_data(ld_data[2]), .busy(busy[2]));

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] flt_of(input int k);
        return (k == 2) ? 32'h0BAD_F00D : 32'h0000_0000;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, got, exp, $time);
        end
    endtask

    // Response word the model predicts for address a at the capture edge.
    task automatic m_capture(input int k);
        logic [31:0] a;
        a = m_addr[k];
        m_err[k]  = ((a % 4) != 0) || (a >= (32'd4 << DL));
        m_inst[k] = m_err[k] ? flt_of(k) : m_mem[k][(a / 4) % 256];
    endtask

    task automatic model_edge();
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_pend[k] = 1'b0;
                m_rsp[k]  = 1'b0;
            end else begin
                if (m_rsp[k]) begin
                    if (rsp_ready[k]) m_rsp[k] = 1'b0;
                end else if (m_pend[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_pend[k] = 1'b0;
                        m_rsp[k]  = 1'b1;
                        m_capture(k);
                    end
                end else if (req_valid[k]) begin
                    m_addr[k] = req_addr[k];
                    if (ws_of(k) == 0) begin
                        m_rsp[k] = 1'b1;
                        m_capture(k);
                    end else begin
                        m_pend[k] = 1'b1;
                        m_left[k] = ws_of(k);
                    end
                end
                // write lands after the read of the same edge
                if (ld_we[k]) m_mem[k][ld_addr[k]] = ld_data[k];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                for (int k = 0; k < N; k++) begin
                    chk("busy", k, 32'(busy[k]), 32'(m_pend[k] | m_rsp[k]));
                    chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_rsp[k]));
                    if (!rst) chk("req_ready", k, 32'(req_ready[k]), 32'(!(m_pend[k] | m_rsp[k])));
                    if (m_rsp[k]) begin
                        chk("rsp_inst", k, rsp_inst[k], m_inst[k]);
                        chk("rsp_err", k, 32'(rsp_err[k]), 32'(m_err[k]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic load(input int k, input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        ld_we[k] = 1'b1; ld_addr[k] = idx; ld_data[k] = d;
        @(negedge clk);
        ld_we[k] = 1'b0;
    endtask

    // One fetch; optional loader write to the read's own index at negedge wr_at.
    task automatic fetch(input int k, input logic [31:0] a, input int hold, input int wr_at,
                         input logic [31:0] wd, output logic [31:0] inst, output logic err,
                         output int lat, output logic rdy_after, output bit done);
        int h;
        bit seen;
        h = 0; seen = 1'b0; done = 1'b0; lat = 0; inst = 32'h0; err = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_addr[k] = a;
        @(negedge clk);
        req_valid[k] = 1'b0; req_addr[k] = 32'hFFFF_FFFF;
        for (int n = 1; n < 60 && !done; n++) begin
            ld_we[k]   = (n == wr_at);
            ld_addr[k] = a[9:2];
            ld_data[k] = wd;
            if (!seen && rsp_valid[k]) begin
                seen = 1'b1;
                lat  = n;
            end
            if (seen && h == hold) begin
                inst = rsp_inst[k];
                err  = rsp_err[k];
                rsp_ready[k] = 1'b1;
                done = 1'b1;
            end else if (seen) begin
                h++;
            end
            @(negedge clk);
        end
        rsp_ready[k] = 1'b0;
        ld_we[k]     = 1'b0;
        rdy_after    = req_ready[k];
    endtask

    task automatic rd(input string nm, input int k, input logic [31:0] a, input int hold,
                      input int wr_at, input logic [31:0] wd,
                      input logic [31:0] exp_inst, input logic exp_err, input int exp_lat);
        logic [31:0] inst;
        logic        err, rdy;
        int          lat;
        bit          done;
        fetch(k, a, hold, wr_at, wd, inst, err, lat, rdy, done);
        chk({nm, "_done"}, k, 32'(done), 32'd1);
        chk({nm, "_inst"}, k, inst, exp_inst);
        chk({nm, "_err"}, k, 32'(err), 32'(exp_err));
        chk({nm, "_lat"}, k, 32'(lat), 32'(exp_lat));
        chk({nm, "_rdy_after"}, k, 32'(rdy), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; ld_we = '0;
        for (int k = 0; k < N; k++) begin
            req_addr[k] = 32'h0; ld_addr[k] = '0; ld_data[k] = 32'h0;
            m_pend[k] = 1'b0; m_rsp[k] = 1'b0; m_left[k] = 0;
            m_addr[k] = 32'h0; m_inst[k] = 32'h0; m_err[k] = 1'b0;
            for (int i = 0; i < 256; i++) m_mem[k][i] = 32'h0;
        end
        running = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
            chk("reset_rsp_inst", k, rsp_inst[k], 32'h0000_0000);
            chk("reset_rsp_err", k, 32'(rsp_err[k]), 32'd0);
            chk("reset_busy", k, 32'(busy[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("req_ready_after_reset", 0, 32'(req_ready), 32'h7);

        // zero wait states: readback and faults
        load(0, 8'd0, 32'h0042_1821);
        load(0, 8'd1, 32'h0062_1822);
        load(0, 8'd255, 32'h8C43_0004);
        rd("ws0_a0", 0, 32'h0000_0000, 0, 0, 32'h0, 32'h0042_1821, 1'b0, 1);
        rd("ws0_a4", 0, 32'h0000_0004, 0, 0, 32'h0, 32'h0062_1822, 1'b0, 1);
        rd("ws0_mis", 0, 32'h0000_0006, 0, 0, 32'h0, 32'h0000_0000, 1'b1, 1);
        rd("ws0_oor", 0, 32'h0000_0400, 0, 0, 32'h0, 32'h0000_0000, 1'b1, 1);
        rd("ws0_top", 0, 32'h0000_03FC, 0, 0, 32'h0, 32'h8C43_0004, 1'b0, 1);

        // three wait states: latency, backpressure, write before/after capture
        load(1, 8'd2, 32'h0085_1820);
        rd("ws3_lat", 1, 32'h0000_0008, 0, 0, 32'h0, 32'h0085_1820, 1'b0, 4);
        rd("ws3_bp", 1, 32'h0000_0008, 5, 0, 32'h0, 32'h0085_1820, 1'b0, 4);
        load(1, 8'd4, 32'h1111_1111);
        rd("ws3_wr_before", 1, 32'h0000_0010, 0, 1, 32'h2222_2222, 32'h2222_2222, 1'b0, 4);
        rd("ws3_wr_after", 1, 32'h0000_0010, 3, 5, 32'h3333_3333, 32'h2222_2222, 1'b0, 4);
        rd("ws3_reread", 1, 32'h0000_0010, 0, 0, 32'h0, 32'h3333_3333, 1'b0, 4);

        // two wait states: same-edge write returns old data
        load(2, 8'd3, 32'h8C62_0000);
        rd("ws2_hazard", 2, 32'h0000_000C, 0, 2, 32'hAC83_003C, 32'h8C62_0000, 1'b0, 3);
        rd("ws2_reread", 2, 32'h0000_000C, 0, 0, 32'h0, 32'hAC83_003C, 1'b0, 3);
        rd("ws2_hifault", 2, 32'h8000_0000, 1, 0, 32'h0, 32'h0BAD_F00D, 1'b1, 3);

        // reset during WAIT: immediate drop, loader ignored, contents kept
        @(negedge clk);
        req_valid[1] = 1'b1; req_addr[1] = 32'h0000_0008;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("pre_reset_busy", 1, 32'(busy[1]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_busy", 1, 32'(busy[1]), 32'd0);
        chk("async_reset_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("async_reset_rsp_inst", 1, rsp_inst[1], 32'h0000_0000);
        ld_we[1] = 1'b1; ld_addr[1] = 8'd2; ld_data[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        ld_we[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 1, 32'(rsp_valid[1]), 32'd0);
        end
        rd("ws3_preserved", 1, 32'h0000_0008, 0, 0, 32'h0, 32'h0085_1820, 1'b0, 4);

        repeat (2) @(negedge clk);
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
